// File: rtl/apb_master.sv
// APB bridge: turns a level CPU request into a SETUP/ACCESS transfer on one of five decoded slaves,
// with a wait-state timeout and an error flag for timeouts and unmapped addresses.
module apb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    output logic        PSEL4,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [31:0] PRDATA4,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3,
    input  logic        PREADY4
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state;
    state_t      nextState;
    logic [7:0]  waitCnt;
    logic [4:0]  sel;
    logic        mapped;
    logic        selReady;
    logic [31:0] selRdata;
    logic        timedOut;
    logic        done;

    // Slave select is decoded from the latched address so it stays stable for the whole transfer
    always_comb begin
        sel = 5'b00000;
        unique case (PADDR[31:12])
            20'h10000: sel = 5'b00001;
            20'h10001: sel = 5'b00010;
            20'h10002: sel = 5'b00100;
            20'h10003: sel = 5'b01000;
            20'h10004: sel = 5'b10000;
            default:   sel = 5'b00000;
        endcase
    end

    always_comb begin
        selRdata = 32'h0000_0000;
        if (sel[0]) selRdata = PRDATA0;
        if (sel[1]) selRdata = PRDATA1;
        if (sel[2]) selRdata = PRDATA2;
        if (sel[3]) selRdata = PRDATA3;
        if (sel[4]) selRdata = PRDATA4;
    end

    assign mapped   = |sel;
    assign selReady = |(sel & {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0});
    assign timedOut = (waitCnt == 8'(TIMEOUT - 1));
    assign done     = (state == ACCESS) && (!mapped || selReady || timedOut);

    // A reset landing on the completing cycle aborts the transfer, so the strobe is masked by it
    assign ready = done && reset;

    assign PENABLE = (state == ACCESS);
    assign {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0} =
        ((state == SETUP) || (state == ACCESS)) ? sel : 5'b00000;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (transfer) nextState = SETUP;
            SETUP:   nextState = ACCESS;
            ACCESS:  if (done) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request capture, wait counting and the registered completion results
    always_ff @(posedge clk) begin
        if (!reset) begin
            PADDR   <= 32'h0000_0000;
            PWDATA  <= 32'h0000_0000;
            PWRITE  <= 1'b0;
            waitCnt <= 8'h00;
            rdata   <= 32'h0000_0000;
            err     <= 1'b0;
        end else begin
            if (state == IDLE && transfer) begin
                PADDR   <= addr;
                PWDATA  <= wdata;
                PWRITE  <= write;
                waitCnt <= 8'h00;
            end
            if (state == ACCESS && !done) begin
                waitCnt <= waitCnt + 8'h01;
            end
            if (done) begin
                err <= !mapped || !selReady;
                if (!PWRITE) begin
                    if (!mapped) begin
                        rdata <= 32'h0000_0000;
                    end else if (selReady) begin
                        rdata <= selRdata;
                    end else begin
                        rdata <= 32'hDEAD_BEEF;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a default-timeout instance for the protocol cases and a
// TIMEOUT=4 instance sharing the same stimulus for the forced-completion case.
module tb_apb_master;

    logic        clk;
    logic        reset;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4;
    logic        PREADY0, PREADY1, PREADY2, PREADY3, PREADY4;

    logic [31:0] rdata, PADDR, PWDATA;
    logic        ready, err, PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
    logic [4:0]  psel;

    logic [31:0] rdataT, paddrT, pwdataT;
    logic        readyT, errT, pwriteT, penableT;
    logic [4:0]  pselT;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    int   passCount  = 0;
    int   totalCount = 0;

    assign psel = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

    apb_master dut (
        .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3), .PRDATA4(PRDATA4),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3), .PREADY4(PREADY4)
    );

    apb_master #(.TIMEOUT(4)) dutT (
        .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdataT), .ready(readyT), .err(errT), .PADDR(paddrT), .PWDATA(pwdataT), .PWRITE(pwriteT),
        .PENABLE(penableT), .PSEL0(pselT[0]), .PSEL1(pselT[1]), .PSEL2(pselT[2]), .PSEL3(pselT[3]),
        .PSEL4(pselT[4]),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3), .PRDATA4(PRDATA4),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3), .PREADY4(PREADY4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic xfer, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d);
        transfer = xfer;
        write    = wr;
        addr     = a;
        wdata    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scoreCheck(input string tag, input logic [31:0] rObs, input logic eObs);
        exp_t e;
        if (sbQ.size() == 0) begin
            totalCount++;
            $error("[TB] FAIL %s: scoreboard empty, observed rdata %h err %b", tag, rObs, eObs);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, "_rdata"}, rObs, e.rdata);
            checkOutput({tag, "_err"}, 32'(eObs), 32'(e.err));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0} = 5'b00000;
        PRDATA0 = 32'h0000_0A00;
        PRDATA1 = 32'hCAFE_0001;
        PRDATA2 = 32'h0000_0A02;
        PRDATA3 = 32'h0000_0A03;
        PRDATA4 = 32'h1234_5678;

        // Reset state after two sampled reset edges
        repeat (2) @(negedge clk);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_ready", 32'(ready), 32'h0);
        checkOutput("rst_paddr", PADDR, 32'h0);
        checkOutput("rst_pwdata", PWDATA, 32'h0);
        checkOutput("rst_pwrite", 32'(PWRITE), 32'h0);
        checkOutput("rst_penable", 32'(PENABLE), 32'h0);
        checkOutput("rst_psel", 32'(psel), 32'h0);
        reset = 1'b1;

        // Zero-wait write to slave 2
        PREADY2 = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h1000_2004, 32'h0000_00A5);
        sbQ.push_back('{rdata: 32'h0, err: 1'b0});
        nextCycle();
        checkOutput("wr_setup_psel", 32'(psel), 32'h04);
        checkOutput("wr_setup_penable", 32'(PENABLE), 32'h0);
        checkOutput("wr_setup_ready", 32'(ready), 32'h0);
        nextCycle();
        checkOutput("wr_access_psel", 32'(psel), 32'h04);
        checkOutput("wr_access_penable", 32'(PENABLE), 32'h1);
        checkOutput("wr_access_ready", 32'(ready), 32'h1);
        checkOutput("wr_paddr", PADDR, 32'h1000_2004);
        checkOutput("wr_pwdata", PWDATA, 32'h0000_00A5);
        checkOutput("wr_pwrite", 32'(PWRITE), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        scoreCheck("wr_done", rdata, err);
        checkOutput("wr_idle_psel", 32'(psel), 32'h0);
        checkOutput("wr_idle_penable", 32'(PENABLE), 32'h0);

        // Read from an unmapped page completes at once with an error
        applyStimulus(1'b1, 1'b0, 32'h2000_0000, 32'h0);
        sbQ.push_back('{rdata: 32'h0, err: 1'b1});
        nextCycle();
        checkOutput("unm_setup_psel", 32'(psel), 32'h0);
        nextCycle();
        checkOutput("unm_access_psel", 32'(psel), 32'h0);
        checkOutput("unm_access_ready", 32'(ready), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        scoreCheck("unm_done", rdata, err);

        // Read from slave 4 with three wait states; a stray PREADY0 must be ignored
        PREADY0 = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h1000_4000, 32'h0);
        sbQ.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        nextCycle();
        checkOutput("rd4_setup_psel", 32'(psel), 32'h10);
        applyStimulus(1'b1, 1'b1, 32'h1000_3000, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("rd4_wait%0d_ready", i), 32'(ready), 32'h0);
            checkOutput($sformatf("rd4_wait%0d_paddr", i), PADDR, 32'h1000_4000);
            checkOutput($sformatf("rd4_wait%0d_psel", i), 32'(psel), 32'h10);
        end
        nextCycle();
        PREADY4 = 1'b1;
        #1;
        checkOutput("rd4_ready", 32'(ready), 32'h1);
        checkOutput("rd4_paddr", PADDR, 32'h1000_4000);
        checkOutput("rd4_pwrite", 32'(PWRITE), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        PREADY4 = 1'b0;
        PREADY0 = 1'b0;
        scoreCheck("rd4_done", rdata, err);
        checkOutput("rd4_single_pulse", 32'(ready), 32'h0);

        // Reset in the second ACCESS cycle of a stalled read aborts it
        applyStimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("abort_acc1_ready", 32'(ready), 32'h0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("abort_acc2_ready", 32'(ready), 32'h0);
        nextCycle();
        reset = 1'b1;
        checkOutput("abort_psel", 32'(psel), 32'h0);
        checkOutput("abort_penable", 32'(PENABLE), 32'h0);
        checkOutput("abort_paddr", PADDR, 32'h0);
        checkOutput("abort_pwrite", 32'(PWRITE), 32'h0);
        checkOutput("abort_rdata", rdata, 32'h0);
        checkOutput("abort_err", 32'(err), 32'h0);
        checkOutput("abort_ready", 32'(ready), 32'h0);

        // Back-to-back: write then read on slave 1 with transfer held high throughout
        PREADY1 = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h1000_1000, 32'h0000_0011);
        sbQ.push_back('{rdata: 32'h0, err: 1'b0});
        nextCycle();
        checkOutput("b2b1_setup_psel", 32'(psel), 32'h02);
        checkOutput("b2b1_setup_penable", 32'(PENABLE), 32'h0);
        nextCycle();
        checkOutput("b2b1_access_penable", 32'(PENABLE), 32'h1);
        checkOutput("b2b1_access_ready", 32'(ready), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h1000_1008, 32'h0);
        nextCycle();
        scoreCheck("b2b1_done", rdata, err);
        checkOutput("b2b_idle_psel", 32'(psel), 32'h0);
        checkOutput("b2b_idle_penable", 32'(PENABLE), 32'h0);
        checkOutput("b2b_idle_ready", 32'(ready), 32'h0);
        sbQ.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
        nextCycle();
        checkOutput("b2b2_setup_psel", 32'(psel), 32'h02);
        checkOutput("b2b2_setup_penable", 32'(PENABLE), 32'h0);
        checkOutput("b2b2_paddr", PADDR, 32'h1000_1008);
        checkOutput("b2b2_pwrite", 32'(PWRITE), 32'h0);
        nextCycle();
        checkOutput("b2b2_access_penable", 32'(PENABLE), 32'h1);
        checkOutput("b2b2_access_ready", 32'(ready), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        PREADY1 = 1'b0;
        scoreCheck("b2b2_done", rdata, err);

        // Timeout on the TIMEOUT=4 instance: slave 0 never answers
        applyStimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0);
        sbQ.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1});
        nextCycle();
        checkOutput("to_setup_psel", 32'(pselT), 32'h01);
        checkOutput("to_setup_penable", 32'(penableT), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            checkOutput($sformatf("to_acc%0d_ready", i), 32'(readyT), 32'h0);
            checkOutput($sformatf("to_acc%0d_penable", i), 32'(penableT), 32'h1);
        end
        nextCycle();
        checkOutput("to_acc4_ready", 32'(readyT), 32'h1);
        checkOutput("to_acc4_paddr", paddrT, 32'h1000_0000);
        checkOutput("to_acc4_pwrite", 32'(pwriteT), 32'h0);
        checkOutput("to_acc4_pwdata", pwdataT, 32'h0);
        checkOutput("to_long_timeout_ready", 32'(ready), 32'h0);
        nextCycle();
        scoreCheck("to_done", rdataT, errT);
        checkOutput("to_idle_psel", 32'(pselT), 32'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
